// File: rtl/pipe_stage_reg.sv
// Cascaded pipeline register (EX/MEM style) with per-stage valid, stall hold and flush kill.
// Optional stall/flush performance counters are built only when PIPE_STAGE_REG_PERF_EN is defined.
module pipe_stage_reg #(
  parameter int WB_W   = 2,
  parameter int M_W    = 2,
  parameter int DATA_W = 32,
  parameter int RD_W   = 5,
  parameter int DEPTH  = 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              valid_i,
  input  logic              stall_i,
  input  logic              flush_i,
  input  logic [WB_W-1:0]   wb_i,
  input  logic [M_W-1:0]    m_i,
  input  logic [DATA_W-1:0] alu_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [RD_W-1:0]   rd_i,
  output logic              valid_o,
  output logic [WB_W-1:0]   wb_o,
  output logic [M_W-1:0]    m_o,
  output logic [DATA_W-1:0] alu_o,
  output logic [DATA_W-1:0] wdata_o,
  output logic [RD_W-1:0]   rd_o,
  output logic [15:0]       stall_cnt_o,
  output logic [15:0]       flush_cnt_o
);

  // Chain index k feeds stage k; index DEPTH is the last stage's registered contents.
  logic              ch_valid [DEPTH+1];
  logic [WB_W-1:0]   ch_wb    [DEPTH+1];
  logic [M_W-1:0]    ch_m     [DEPTH+1];
  logic [DATA_W-1:0] ch_alu   [DEPTH+1];
  logic [DATA_W-1:0] ch_wdata [DEPTH+1];
  logic [RD_W-1:0]   ch_rd    [DEPTH+1];

  // A bubble never carries live control bits into the pipe.
  assign ch_valid[0] = valid_i;
  assign ch_wb[0]    = valid_i ? wb_i : '0;
  assign ch_m[0]     = valid_i ? m_i  : '0;
  assign ch_alu[0]   = alu_i;
  assign ch_wdata[0] = wdata_i;
  assign ch_rd[0]    = rd_i;

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    logic              valid_q, valid_d;
    logic [WB_W-1:0]   wb_q, wb_d;
    logic [M_W-1:0]    m_q, m_d;
    logic [DATA_W-1:0] alu_q, alu_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [RD_W-1:0]   rd_q, rd_d;

    always_comb begin
      valid_d = valid_q;
      wb_d    = wb_q;
      m_d     = m_q;
      alu_d   = alu_q;
      wdata_d = wdata_q;
      rd_d    = rd_q;
      // Flush wins over stall and only kills control; payload fields are left as-is.
      if (flush_i) begin
        valid_d = 1'b0;
        wb_d    = '0;
        m_d     = '0;
      end else if (!stall_i) begin
        valid_d = ch_valid[k];
        wb_d    = ch_wb[k];
        m_d     = ch_m[k];
        alu_d   = ch_alu[k];
        wdata_d = ch_wdata[k];
        rd_d    = ch_rd[k];
      end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        valid_q <= 1'b0;
        wb_q    <= '0;
        m_q     <= '0;
        alu_q   <= '0;
        wdata_q <= '0;
        rd_q    <= '0;
      end else begin
        valid_q <= valid_d;
        wb_q    <= wb_d;
        m_q     <= m_d;
        alu_q   <= alu_d;
        wdata_q <= wdata_d;
        rd_q    <= rd_d;
      end
    end

    assign ch_valid[k+1] = valid_q;
    assign ch_wb[k+1]    = wb_q;
    assign ch_m[k+1]     = m_q;
    assign ch_alu[k+1]   = alu_q;
    assign ch_wdata[k+1] = wdata_q;
    assign ch_rd[k+1]    = rd_q;
  end

  assign valid_o = ch_valid[DEPTH];
  assign wb_o    = ch_wb[DEPTH];
  assign m_o     = ch_m[DEPTH];
  assign alu_o   = ch_alu[DEPTH];
  assign wdata_o = ch_wdata[DEPTH];
  assign rd_o    = ch_rd[DEPTH];

`ifdef PIPE_STAGE_REG_PERF_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;
  logic [15:0] flush_cnt_q, flush_cnt_d;

  // Saturating counters: once at all-ones they stay there.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall_i && !flush_i && (stall_cnt_q != 16'hFFFF))
      stall_cnt_d = stall_cnt_q + 16'd1;
    if (flush_i && (flush_cnt_q != 16'hFFFF))
      flush_cnt_d = flush_cnt_q + 16'd1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;
`else
  assign stall_cnt_o = '0;
  assign flush_cnt_o = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: three instances (DEPTH 1, 2, 3) share one stimulus stream.
// Counter checks follow PIPE_STAGE_REG_PERF_EN the same way the design does.
module tb_pipe_stage_reg;

  localparam int RW = 74;  // {valid, wb[2], m[2], alu[32], wdata[32], rd[5]}

  typedef struct {
    logic        v;
    logic [1:0]  wb;
    logic [1:0]  m;
    logic [31:0] alu;
    logic [31:0] wd;
    logic [4:0]  rd;
    logic [1:0]  ewb;
    logic [1:0]  em;
  } vec_t;

  logic clk, rst_i, valid_i, stall_i, flush_i;
  logic [1:0] wb_i, m_i;
  logic [31:0] alu_i, wdata_i;
  logic [4:0] rd_i;

  logic v1, v2, v3;
  logic [1:0] wb1, wb2, wb3, m1, m2, m3;
  logic [31:0] alu1, alu2, alu3, wd1, wd2, wd3;
  logic [4:0] rd1, rd2, rd3;
  logic [15:0] sc1, sc2, sc3, fc1, fc2, fc3;
  logic [RW-1:0] o1, o2, o3;

  assign o1 = {v1, wb1, m1, alu1, wd1, rd1};
  assign o2 = {v2, wb2, m2, alu2, wd2, rd2};
  assign o3 = {v3, wb3, m3, alu3, wd3, rd3};

  pipe_stage_reg #(.DEPTH(1)) u1 (
    .clk_i(clk), .rst_i(rst_i), .valid_i(valid_i), .stall_i(stall_i), .flush_i(flush_i),
    .wb_i(wb_i), .m_i(m_i), .alu_i(alu_i), .wdata_i(wdata_i), .rd_i(rd_i),
    .valid_o(v1), .wb_o(wb1), .m_o(m1), .alu_o(alu1), .wdata_o(wd1), .rd_o(rd1),
    .stall_cnt_o(sc1), .flush_cnt_o(fc1));

  pipe_stage_reg #(.DEPTH(2)) u2 (
    .clk_i(clk), .rst_i(rst_i), .valid_i(valid_i), .stall_i(stall_i), .flush_i(flush_i),
    .wb_i(wb_i), .m_i(m_i), .alu_i(alu_i), .wdata_i(wdata_i), .rd_i(rd_i),
    .valid_o(v2), .wb_o(wb2), .m_o(m2), .alu_o(alu2), .wdata_o(wd2), .rd_o(rd2),
    .stall_cnt_o(sc2), .flush_cnt_o(fc2));

  pipe_stage_reg #(.DEPTH(3)) u3 (
    .clk_i(clk), .rst_i(rst_i), .valid_i(valid_i), .stall_i(stall_i), .flush_i(flush_i),
    .wb_i(wb_i), .m_i(m_i), .alu_i(alu_i), .wdata_i(wdata_i), .rd_i(rd_i),
    .valid_o(v3), .wb_o(wb3), .m_o(m3), .alu_o(alu3), .wdata_o(wd3), .rd_o(rd3),
    .stall_cnt_o(sc3), .flush_cnt_o(fc3));

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [RW-1:0] exp1_q[$], exp2_q[$], exp3_q[$];
  vec_t tbl[14];

  task automatic chk(input string name, input logic [RW-1:0] act, input logic [RW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [RW-1:0] r, input logic st, input logic fl);
    {valid_i, wb_i, m_i, alu_i, wdata_i, rd_i} = r;
    stall_i = st;
    flush_i = fl;
  endtask

  task automatic do_reset();
    drive('0, 1'b0, 1'b0);
    rst_i = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_i = 1'b0;
    chk("reset_o1", o1, '0);
    chk("reset_o2", o2, '0);
    chk("reset_o3", o3, '0);
    chk("reset_cnt", {58'd0, sc1, fc1}, '0);
  endtask

  logic [RW-1:0] ra, rb, rc, rz, rexp;

  initial begin
    rst_i = 1'b1;
    // REQ-style table: inputs plus expected wb/m at output
    tbl[0] = '{1'b1, 2'b11, 2'b00, 32'h0000_1234, 32'h0,         5'd7,  2'b11, 2'b00};
    tbl[1] = '{1'b0, 2'b11, 2'b01, 32'hDEAD_BEEF, 32'hCAFE_F00D, 5'd31, 2'b00, 2'b00};
    tbl[2] = '{1'b1, 2'b01, 2'b10, 32'hFFFF_FFFF, 32'h0,         5'd0,  2'b01, 2'b10};
    tbl[3] = '{1'b1, 2'b10, 2'b11, 32'h0,         32'hFFFF_FFFF, 5'd31, 2'b10, 2'b11};
    tbl[4] = '{1'b0, 2'b10, 2'b10, 32'h1111_2222, 32'h3333_4444, 5'd3,  2'b00, 2'b00};
    tbl[5] = '{1'b1, 2'b00, 2'b01, 32'hA5A5_A5A5, 32'h5A5A_5A5A, 5'd16, 2'b00, 2'b01};
    tbl[6] = '{1'b1, 2'b11, 2'b11, 32'h8000_0000, 32'h1,         5'd1,  2'b11, 2'b11};
    tbl[7] = '{1'b0, 2'b01, 2'b11, 32'h1234_5678, 32'h9ABC_DEF0, 5'd15, 2'b00, 2'b00};
    for (int i = 8; i < 14; i++) begin
      tbl[i].v   = 1'($urandom_range(0, 1));
      tbl[i].wb  = 2'($urandom_range(0, 3));
      tbl[i].m   = 2'($urandom_range(0, 3));
      tbl[i].alu = $urandom;
      tbl[i].wd  = $urandom;
      tbl[i].rd  = 5'($urandom_range(0, 31));
      tbl[i].ewb = tbl[i].v ? tbl[i].wb : 2'b00;
      tbl[i].em  = tbl[i].v ? tbl[i].m  : 2'b00;
    end

    // streaming through all depths with a scoreboard per instance
    do_reset();
    exp1_q.delete(); exp2_q.delete(); exp3_q.delete();
    exp2_q.push_back('0);
    exp3_q.push_back('0);
    exp3_q.push_back('0);
    for (int i = 0; i < 14; i++) begin
      drive({tbl[i].v, tbl[i].wb, tbl[i].m, tbl[i].alu, tbl[i].wd, tbl[i].rd}, 1'b0, 1'b0);
      rexp = {tbl[i].v, tbl[i].ewb, tbl[i].em, tbl[i].alu, tbl[i].wd, tbl[i].rd};
      exp1_q.push_back(rexp);
      exp2_q.push_back(rexp);
      exp3_q.push_back(rexp);
      tick();
      chk($sformatf("stream_d1_%0d", i), o1, exp1_q.pop_front());
      chk($sformatf("stream_d2_%0d", i), o2, exp2_q.pop_front());
      chk($sformatf("stream_d3_%0d", i), o3, exp3_q.pop_front());
    end

    // DEPTH=3 stall sequence: A,B,C, one advance, two stall edges, release
    ra = {1'b1, 2'b01, 2'b10, 32'hAAAA_0001, 32'hA0A0_0001, 5'd10};
    rb = {1'b1, 2'b10, 2'b01, 32'hBBBB_0002, 32'hB0B0_0002, 5'd11};
    rc = {1'b1, 2'b11, 2'b11, 32'hCCCC_0003, 32'hC0C0_0003, 5'd12};
    rz = '0;
    do_reset();
    drive(ra, 1'b0, 1'b0); tick(); chk("stall_e1", o3, rz);
    drive(rb, 1'b0, 1'b0); tick(); chk("stall_e2", o3, rz);
    drive(rc, 1'b0, 1'b0); tick(); chk("stall_e3_A", o3, ra);
    drive(rz, 1'b0, 1'b0); tick(); chk("stall_e4_B", o3, rb);
    drive(rz, 1'b1, 1'b0); tick(); chk("stall_hold1_B", o3, rb);
    drive(rz, 1'b1, 1'b0); tick(); chk("stall_hold2_B", o3, rb);
    drive(rz, 1'b0, 1'b0); tick(); chk("stall_rel_C", o3, rc);
    drive(rz, 1'b0, 1'b0); tick(); chk("stall_drain", o3, rz);

    // DEPTH=2 flush overriding stall with two valid entries in flight
    do_reset();
    drive(ra, 1'b0, 1'b0); tick(); chk("flush_e1", o2, rz);
    drive(rb, 1'b0, 1'b0); tick(); chk("flush_e2", o2, ra);
    drive(rc, 1'b1, 1'b1); tick();
    chk("flush_edge", o2, {1'b0, 2'b00, 2'b00, 32'hAAAA_0001, 32'hA0A0_0001, 5'd10});
    drive(rz, 1'b0, 1'b0); tick();
    chk("flush_next", o2, {1'b0, 2'b00, 2'b00, 32'hBBBB_0002, 32'hB0B0_0002, 5'd11});

    // asynchronous reset between edges with data in flight
    do_reset();
    drive(ra, 1'b0, 1'b0); tick();
    drive(rb, 1'b0, 1'b0); tick();
    drive(rc, 1'b0, 1'b0); tick();
    chk("async_pre", o1, rc);
    #2 rst_i = 1'b1;
    #1;
    chk("async_o1", o1, rz);
    chk("async_o2", o2, rz);
    chk("async_o3", o3, rz);
    #1 rst_i = 1'b0;
    drive(rb, 1'b0, 1'b0); tick();
    chk("post_rst_d1", o1, rb);
    chk("post_rst_d2", o2, rz);

    // performance counters under long stall, then flushes
    do_reset();
    drive(rz, 1'b1, 1'b0);
    for (int i = 1; i <= 65540; i++) begin
      tick();
`ifdef PIPE_STAGE_REG_PERF_EN
      if (i == 100) chk("stall_cnt_100", {58'd0, sc1}, 74'd100);
      if (i == 65535) chk("stall_cnt_sat", {58'd0, sc1}, 74'hFFFF);
`else
      if ((i % 8192) == 0) chk("stall_cnt_off", {58'd0, sc1}, '0);
`endif
    end
    drive(rz, 1'b1, 1'b1);
    repeat (3) tick();
`ifdef PIPE_STAGE_REG_PERF_EN
    chk("stall_cnt_hold", {58'd0, sc1}, 74'hFFFF);
    chk("flush_cnt_3", {58'd0, fc1}, 74'd3);
    chk("stall_cnt_d3", {58'd0, sc3}, 74'hFFFF);
`else
    chk("stall_cnt_end", {58'd0, sc1}, '0);
    chk("flush_cnt_off", {58'd0, fc1}, '0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 SHALL have parameter WB_W, default 2, width of write-back control field.
REQ-002 SHALL have parameter M_W, default 2, width of memory control field.
REQ-003 SHALL have parameter DATA_W, default 32, width of ALU result and store-data fields.
REQ-004 SHALL have parameter RD_W, default 5, width of destination-register field.
REQ-005 SHALL have parameter DEPTH, default 1, legal 1..4, number of cascaded register stages.
REQ-006 SHALL have one clock and an asynchronous, active-high reset: clk_i input 1 (rising-edge clock); rst_i input 1 (asynchronous active-high reset).
REQ-007 SHALL have these ports:
- valid_i input 1: incoming slot holds a real instruction.
- stall_i input 1: hold all stages.
- flush_i input 1: kill all in-flight instructions.
- wb_i input WB_W, m_i input M_W: control fields.
- alu_i input DATA_W, wdata_i input DATA_W: data fields.
- rd_i input RD_W: destination register.
- valid_o output 1; wb_o output WB_W; m_o output M_W; alu_o output DATA_W; wdata_o output DATA_W; rd_o output RD_W: last-stage contents.
- stall_cnt_o output 16; flush_cnt_o output 16: performance counters.

Function
REQ-008 SHALL advance every stage k from stage k-1 (stage 0 from inputs) on each rising clk_i edge where stall_i=0 and flush_i=0; latency DEPTH cycles.
REQ-009 SHALL hold every stage unchanged on an edge where stall_i=1 and flush_i=0.
REQ-010 SHALL, on an edge where flush_i=1, clear valid, wb and m of every stage to 0 and leave alu, wdata, rd unchanged; flush overrides stall.
REQ-011 SHALL load wb and m of stage 0 as 0 whenever valid_i=0 (bubble), regardless of wb_i/m_i; alu, wdata and rd load from inputs.
REQ-012 SHALL drive all outputs directly from last-stage registers, with no combinational path from inputs to outputs.
REQ-013 SHALL guarantee wb_o=0 and m_o=0 whenever valid_o=0.
REQ-014 SHALL treat each stage independently of its downstream neighbour; no bubble collapsing; a stall freezes the whole chain.

Reset
REQ-015 SHALL, while rst_i=1, asynchronously force all stages' valid, wb, m, alu, wdata and rd to 0, so every output reads 0.
REQ-016 SHALL discard in-flight contents when rst_i asserts mid-operation; the first edge after deassertion behaves per REQ-008..011.
REQ-017 SHALL reset stall_cnt_o and flush_cnt_o to 0.

Configuration
REQ-018 SHALL compile the performance counters only when macro PIPE_STAGE_REG_PERF_EN is defined.
REQ-019 SHALL, with PIPE_STAGE_REG_PERF_EN defined:
- increment stall_cnt_o on each edge with stall_i=1 and flush_i=0;
- increment flush_cnt_o on each edge with flush_i=1;
- saturate both counters at 16'hFFFF, with no wrap.
REQ-020 SHALL, without PIPE_STAGE_REG_PERF_EN, keep both counter ports present, tied to constant 0, with no counter flops.

Verification
REQ-021 SHALL cover: DEPTH=1, reset, then valid_i=1, wb_i=2'b11, alu_i=32'h0000_1234, rd_i=5'd7 -> one edge later valid_o=1, wb_o=2'b11, alu_o=32'h0000_1234, rd_o=7.
REQ-022 SHALL cover: DEPTH=3, values A, B, C on consecutive cycles, then stall_i=1 for 2 cycles -> A appears at output 3 cycles after entry; B holds at output for both stall cycles; C follows after stall release.
REQ-023 SHALL cover: DEPTH=2, two valid entries in flight, stall_i=1 and flush_i=1 on the same edge -> valid_o=0, wb_o=0, m_o=0 on that edge and the next; alu_o keeps its prior value.
REQ-024 SHALL cover: valid_i=0 with wb_i=2'b11, m_i=2'b01 -> after DEPTH edges, valid_o=0, wb_o=0, m_o=0.
REQ-025 SHALL cover: rst_i pulsed between clock edges with data in flight -> all outputs read 0 immediately, without waiting for clk_i.
REQ-026 SHALL cover: PIPE_STAGE_REG_PERF_EN defined, stall_i=1 held for 65540 cycles -> stall_cnt_o=16'hFFFF and stays there; without the macro, stall_cnt_o=0 throughout.
